// File: rtl/cla_stream_sequencer_pkg.sv
// Shared definitions for the CLA stream sequencer.
//   - seq_state_e : sequencer FSM states
//   - DefaultN/W  : default operand width and stream beat width
//   - calc_beats  : beats per operand/result
//   - idx_width   : beat-index register width (at least 1 bit)
package cla_stream_sequencer_pkg;

    typedef enum logic [1:0] {
        StLoadA = 2'd0,
        StLoadB = 2'd1,
        StAdd   = 2'd2,
        StDrain = 2'd3
    } seq_state_e;

    localparam int unsigned DefaultN = 256;
    localparam int unsigned DefaultW = 32;

    function automatic int unsigned calc_beats(input int unsigned n, input int unsigned w);
        return n / w;
    endfunction

    function automatic int unsigned idx_width(input int unsigned beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/cla_stream_sequencer.sv
// Stream sequencer for an external combinational N-bit adder.
// Collects operand A then operand B as BEATS W-bit beats (LS beat first), holds them on the
// adder inputs, captures sum/carry-out after a single ADD cycle and drains the sum as BEATS
// W-bit beats. Chain mode reuses the previous carry-out as carry-in.
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   in_valid_i/in_ready_o/in_data_i      operand input stream
//   in_cin_i, in_chain_i                 carry-in / chain enable, taken on first A beat
//   add_a_o/add_b_o/add_cin_o            drive to adder
//   add_s_i/add_cout_i                   result from adder
//   out_valid_o/out_ready_i/out_data_o   result output stream
//   out_last_o, out_cout_o               final-beat marker, captured carry-out
//   busy_o                               op in progress
module cla_stream_sequencer
    import cla_stream_sequencer_pkg::*;
#(
    parameter int unsigned N = DefaultN,
    parameter int unsigned W = DefaultW
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         in_cin_i,
    input  logic         in_chain_i,
    output logic [N-1:0] add_a_o,
    output logic [N-1:0] add_b_o,
    output logic         add_cin_o,
    input  logic [N-1:0] add_s_i,
    input  logic         add_cout_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         out_last_o,
    output logic         out_cout_o,
    output logic         busy_o
);

    localparam int unsigned BEATS = calc_beats(N, W);
    localparam int unsigned IdxW  = idx_width(BEATS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BEATS - 1);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    if ((W == 0) || ((N % W) != 0)) begin : gen_bad_width
        $error("cla_stream_sequencer: N must be a non-zero integer multiple of W");
    end

    seq_state_e    state_q;
    logic [IdxW-1:0] idx_q;
    logic [N-1:0]  a_q, b_q, s_q;
    logic          cin_q, cout_q;
    logic          in_ready_q, out_valid_q, out_last_q, busy_q;

    logic in_hs, out_hs;
    assign in_hs  = in_valid_i & in_ready_q;
    assign out_hs = out_valid_q & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StLoadA;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            cin_q       <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StLoadA: begin
                    if (in_hs) begin
                        a_q[idx_q*W +: W] <= in_data_i;
                        busy_q            <= 1'b1;
                        if (idx_q == '0) begin
                            cin_q <= in_chain_i ? cout_q : in_cin_i;
                        end
                        if (idx_q == LastIdx) begin
                            idx_q   <= '0;
                            state_q <= StLoadB;
                        end else begin
                            idx_q <= idx_q + IdxOne;
                        end
                    end
                end
                StLoadB: begin
                    if (in_hs) begin
                        b_q[idx_q*W +: W] <= in_data_i;
                        if (idx_q == LastIdx) begin
                            idx_q      <= '0;
                            state_q    <= StAdd;
                            in_ready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IdxOne;
                        end
                    end
                end
                StAdd: begin
                    // Adder inputs have been stable for this whole cycle.
                    s_q         <= add_s_i;
                    cout_q      <= add_cout_i;
                    state_q     <= StDrain;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (BEATS == 1);
                end
                StDrain: begin
                    if (out_hs) begin
                        if (idx_q == LastIdx) begin
                            idx_q       <= '0;
                            state_q     <= StLoadA;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            idx_q      <= idx_q + IdxOne;
                            out_last_q <= ((idx_q + IdxOne) == LastIdx);
                        end
                    end
                end
            endcase
        end
    end

    assign add_a_o     = a_q;
    assign add_b_o     = b_q;
    assign add_cin_o   = cin_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_cout_o  = cout_q;
    assign busy_o      = busy_q;
    // s_q is read out only while draining; otherwise the beat bus is held at zero.
    assign out_data_o  = out_valid_q ? s_q[idx_q*W +: W] : '0;

endmodule

// File: tb/tb_cla_stream_sequencer.sv
module tb_cla_stream_sequencer;

    localparam int unsigned N = 256;
    localparam int unsigned W = 32;
    localparam int unsigned BEATS = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         cout;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_cin;
    logic         in_chain;
    logic [N-1:0] add_a, add_b, add_s;
    logic         add_cin, add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_cout;
    logic         busy;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    bit   lat_armed = 0;
    int   drain_idx = 0;
    bit   bp_en = 0;
    int   stall_cnt = 0;

    cla_stream_sequencer #(.N(N), .W(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_cin_i    (in_cin),
        .in_chain_i  (in_chain),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_cin_o   (add_cin),
        .add_s_i     (add_s),
        .add_cout_i  (add_cout),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_cout_o  (out_cout),
        .busy_o      (busy)
    );

    // Stand-in for the combinational 256-bit adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_cout"},  out_cout,  0);
        check({tag, "_add_a"},     add_a,     0);
        check({tag, "_add_b"},     add_b,     0);
        check({tag, "_add_cin"},   add_cin,   0);
    endtask

    // Output-ready driver: stalls for 5 cycles at beat 3 when backpressure is enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en && out_valid && drain_idx == 3 && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        exp_t         e;
        bit           stalled;
        logic [W-1:0] held_data;
        logic         held_last, held_cout;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                check("in_ready_low_while_draining", in_ready, 0);
                if (lat_armed) begin
                    check("first_out_valid_latency", cyc, hs_cyc + 2);
                    lat_armed = 0;
                end
                if (stalled) begin
                    check("stall_out_data_stable", out_data, held_data);
                    check("stall_out_last_stable", out_last, held_last);
                    check("stall_out_cout_stable", out_cout, held_cout);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_last", out_last, e.last);
                        check("out_cout", out_cout, e.cout);
                    end
                    drain_idx = out_last ? 0 : drain_idx + 1;
                    stalled = 0;
                end else begin
                    stalled   = 1;
                    held_data = out_data;
                    held_last = out_last;
                    held_cout = out_cout;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic send_beat(input logic [W-1:0] d, input logic cin, input logic chain,
                             input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = cin;
        in_chain = chain;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 100 cycles");
        end
        hs_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                          input logic chain, input logic [N-1:0] exp_s, input logic exp_c,
                          input int max_gap);
        int t;
        for (int k = 0; k < BEATS; k++) begin
            exp_t e;
            e.data = exp_s[k*W +: W];
            e.last = (k == BEATS - 1);
            e.cout = exp_c;
            exp_q.push_back(e);
        end
        for (int k = 0; k < BEATS; k++)
            send_beat(a[k*W +: W], cin, chain, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        for (int k = 0; k < BEATS; k++)
            send_beat(b[k*W +: W], cin, chain, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        lat_armed = 1;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        if (lat_armed) begin
            checks++;
            errors++;
            $display("FAIL no_out_valid: got no result beat, expected one");
            lat_armed = 0;
        end
    endtask

    initial begin : stim
        logic [N-1:0] a, b, s;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_cin   = 1'b0;
        in_chain = 1'b0;
        #3 rst_n = 1'b0;
        #10;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Carry ripple: all-ones + 1 -> sum 0, carry-out 1.
        run_op({N{1'b1}}, 256'd1, 1'b0, 1'b0, 256'd0, 1'b1, 0);

        // Chain: 0 + 0 + previous carry (1) -> 1.
        run_op(256'd0, 256'd0, 1'b0, 1'b1, 256'd1, 1'b0, 0);

        // Ordering: A beat k = k, B beat k = 0x10*k, cin=1 -> beat k = 0x11*k, beat0 = 1.
        for (int k = 0; k < BEATS; k++) begin
            a[k*W +: W] = W'(k);
            b[k*W +: W] = W'(16 * k);
            s[k*W +: W] = (k == 0) ? 32'h1 : W'(17 * k);
        end
        run_op(a, b, 1'b1, 1'b0, s, 1'b0, 0);

        // Same op with random input gaps.
        run_op(a, b, 1'b1, 1'b0, s, 1'b0, 3);

        // Backpressure at beat 3 on a carry-ripple op (leaves carry-out = 1).
        bp_en = 1;
        run_op({N{1'b1}}, 256'd1, 1'b0, 1'b0, 256'd0, 1'b1, 0);
        bp_en = 0;
        check("backpressure_stall_cycles", stall_cnt, 5);

        // Reset during LOAD_B beat 4.
        for (int k = 0; k < BEATS; k++) send_beat(32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) send_beat(32'h1234_0000 + k, 1'b0, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Chain after reset: carry was cleared, so 5 + 7 + 0 = 12.
        run_op(256'd5, 256'd7, 1'b0, 1'b1, 256'd12, 1'b0, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
